// File: rtl/sort_collect_if.sv
// Stream-in / random-read-out bundle between the sorter output and its collector.
// Optional checksum output exists only when SORT_COLLECT_CHECKSUM_EN is defined.
interface sort_collect_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 3
);
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             clear;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic [AW:0]      count;
  logic             order_err;
  logic [AW-1:0]    err_index;
  logic             short_frame;
  logic             overflow;
`ifdef SORT_COLLECT_CHECKSUM_EN
  logic [WIDTH+AW-1:0] checksum;
`endif

  modport master (
    output d, d_valid, clear, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done, count, order_err, err_index,
           short_frame, overflow
`ifdef SORT_COLLECT_CHECKSUM_EN
    , input checksum
`endif
  );

  modport slave (
    input  d, d_valid, clear, rd_en, rd_addr,
    output rd_data, rd_valid, busy, done, count, order_err, err_index,
           short_frame, overflow
`ifdef SORT_COLLECT_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/sort_collect.sv
// Captures one sorter frame, checks ordering/length, serves a 1-cycle read port; no backpressure
// (every valid word is taken or counted as overflow). Optional checksum: SORT_COLLECT_CHECKSUM_EN.
module sort_collect #(
  parameter int SIZE       = 8,
  parameter int WIDTH      = 32,
  parameter int DESCENDING = 1,
  parameter int AW         = 3
) (
  input logic          clk,
  input logic          rst,
  sort_collect_if.slave bus
);

  localparam logic [AW:0] SIZE_C = SIZE[AW:0];

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] prev;
  logic [AW:0]      count_q;
  logic             order_err_q;
  logic [AW-1:0]    err_index_q;
  logic             short_q;
  logic             overflow_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  logic start, accept, discard, finish, flush, violation;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A valid word in DONE starts a new frame even if clear is also high.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    discard   = 1'b0;
    finish    = 1'b0;
    flush     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.d_valid) begin
          start     = 1'b1;
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (bus.d_valid) begin
          if (count_q < SIZE_C) accept  = 1'b1;
          else                  discard = 1'b1;
        end else begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.d_valid) begin
          start     = 1'b1;
          state_nxt = S_CAPTURE;
        end else if (bus.clear) begin
          flush     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    if (DESCENDING != 0) violation = bus.d > prev;
    else                 violation = bus.d < prev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev        <= '0;
      count_q     <= '0;
      order_err_q <= 1'b0;
      err_index_q <= '0;
      short_q     <= 1'b0;
      overflow_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];

      if (start) begin
        prev        <= bus.d;
        count_q     <= {{AW{1'b0}}, 1'b1};
        order_err_q <= 1'b0;
        err_index_q <= '0;
        short_q     <= 1'b0;
        overflow_q  <= 1'b0;
      end
      // Discarded overflow words still take part in the ordering check.
      if (accept || discard) begin
        prev <= bus.d;
        if (violation && !order_err_q) begin
          order_err_q <= 1'b1;
          err_index_q <= count_q[AW-1:0];
        end
      end
      if (accept)  count_q    <= count_q + 1'b1;
      if (discard) overflow_q <= 1'b1;
      if (finish)  short_q    <= count_q < SIZE_C;
      if (flush) begin
        order_err_q <= 1'b0;
        err_index_q <= '0;
        short_q     <= 1'b0;
        overflow_q  <= 1'b0;
      end
    end
  end

  // Frame storage is deliberately unreset; reads of unwritten slots return stale data.
  always_ff @(posedge clk) begin
    if (start)  mem[0]                 <= bus.d;
    if (accept) mem[count_q[AW-1:0]]   <= bus.d;
  end

`ifdef SORT_COLLECT_CHECKSUM_EN
  localparam int CW = WIDTH + AW;
  logic [CW-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sum_q <= '0;
    else if (start)  sum_q <= CW'(bus.d);
    else if (accept) sum_q <= sum_q + CW'(bus.d);
  end

  assign bus.checksum = sum_q;
`endif

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.busy        = (state == S_CAPTURE);
  assign bus.done        = (state == S_DONE);
  assign bus.count       = count_q;
  assign bus.order_err   = order_err_q;
  assign bus.err_index   = err_index_q;
  assign bus.short_frame = short_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_sort_collect.sv
// Directed-vector bench for sort_collect (SIZE=8, WIDTH=32, DESCENDING=1, AW=3).
module tb_sort_collect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] s2 [8] = '{90, 80, 85, 60, 60, 40, 50, 20};

  sort_collect_if #(.WIDTH(32), .AW(3)) sif ();

  sort_collect #(.SIZE(8), .WIDTH(32), .DESCENDING(1), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    sif.d       = w;
    sif.d_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic end_frame();
    sif.d_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    sif.rd_en   = 1'b1;
    sif.rd_addr = a;
    @(posedge clk); #1;
    sif.rd_en = 1'b0;
    chk({tag, "_vld"}, 64'(sif.rd_valid), 64'd1);
    chk(tag, 64'(sif.rd_data), 64'(exp));
  endtask

  initial begin
    sif.d       = '0;
    sif.d_valid = 1'b0;
    sif.clear   = 1'b0;
    sif.rd_en   = 1'b0;
    sif.rd_addr = '0;
    #3;
    chk("rst_busy",  64'(sif.busy), 64'd0);
    chk("rst_done",  64'(sif.done), 64'd0);
    chk("rst_count", 64'(sif.count), 64'd0);
    chk("rst_flags", 64'({sif.order_err, sif.short_frame, sif.overflow}), 64'd0);
    chk("rst_rd",    64'({sif.rd_valid, sif.rd_data}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean descending frame
    for (int v = 90; v >= 20; v -= 10) send(32'(v));
    chk("t1_busy_last", 64'(sif.busy), 64'd1);
    chk("t1_done_early", 64'(sif.done), 64'd0);
    end_frame();
    chk("t1_done",  64'(sif.done), 64'd1);
    chk("t1_busy",  64'(sif.busy), 64'd0);
    chk("t1_count", 64'(sif.count), 64'd8);
    chk("t1_flags", 64'({sif.order_err, sif.short_frame, sif.overflow}), 64'd0);
    rd("t1_rd3", 3'd3, 32'd60);
    rd("t1_rd0", 3'd0, 32'd90);
    rd("t1_rd7", 3'd7, 32'd20);
    @(posedge clk); #1;
    chk("t1_rdv_low", 64'(sif.rd_valid), 64'd0);
    chk("t1_rd_hold", 64'(sif.rd_data), 64'd20);

    // Implicit clear from DONE; two violations, equal pair legal
    send(s2[0]);
    chk("t2_done_drop", 64'(sif.done), 64'd0);
    chk("t2_busy", 64'(sif.busy), 64'd1);
    for (int i = 1; i < 8; i++) send(s2[i]);
    end_frame();
    chk("t2_order_err", 64'(sif.order_err), 64'd1);
    chk("t2_err_index", 64'(sif.err_index), 64'd2);
    chk("t2_count", 64'(sif.count), 64'd8);
    chk("t2_short", 64'(sif.short_frame), 64'd0);

    // Explicit clear: flags gone, count held
    sif.clear = 1'b1;
    @(posedge clk); #1;
    sif.clear = 1'b0;
    chk("clr_done", 64'(sif.done), 64'd0);
    chk("clr_order_err", 64'(sif.order_err), 64'd0);
    chk("clr_count", 64'(sif.count), 64'd8);

    // Short frame
    for (int v = 9; v >= 1; v -= 2) send(32'(v));
    end_frame();
    chk("t3_short", 64'(sif.short_frame), 64'd1);
    chk("t3_count", 64'(sif.count), 64'd5);
    chk("t3_done", 64'(sif.done), 64'd1);
    rd("t3_rd4", 3'd4, 32'd1);
    rd("t3_stale6", 3'd6, 32'd50);

    // Overflow frame
    for (int v = 100; v >= 91; v--) send(32'(v));
    end_frame();
    chk("t4_overflow", 64'(sif.overflow), 64'd1);
    chk("t4_count", 64'(sif.count), 64'd8);
    chk("t4_order_err", 64'(sif.order_err), 64'd0);
    chk("t4_short", 64'(sif.short_frame), 64'd0);
`ifdef SORT_COLLECT_CHECKSUM_EN
    chk("t4_checksum", 64'(sif.checksum), 64'd772);
`endif
    rd("t4_rd7", 3'd7, 32'd93);
    rd("t4_rd0", 3'd0, 32'd100);

    // clear together with d_valid: new frame wins
    sif.clear = 1'b1;
    send(32'd8);
    sif.clear = 1'b0;
    chk("cv_done", 64'(sif.done), 64'd0);
    chk("cv_busy", 64'(sif.busy), 64'd1);
    chk("cv_overflow", 64'(sif.overflow), 64'd0);
    chk("cv_count", 64'(sif.count), 64'd1);
    for (int v = 7; v >= 1; v--) send(32'(v));
    end_frame();
    chk("cv_count_end", 64'(sif.count), 64'd8);
    chk("cv_flags", 64'({sif.order_err, sif.short_frame, sif.overflow}), 64'd0);
`ifdef SORT_COLLECT_CHECKSUM_EN
    chk("cv_checksum", 64'(sif.checksum), 64'd36);
`endif

    // Asynchronous reset mid-frame
    for (int v = 50; v >= 48; v--) send(32'(v));
    chk("mr_busy_pre", 64'(sif.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mr_busy", 64'(sif.busy), 64'd0);
    chk("mr_count", 64'(sif.count), 64'd0);
    chk("mr_done", 64'(sif.done), 64'd0);
    sif.d_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mr_idle", 64'({sif.busy, sif.done}), 64'd0);
    for (int v = 70; v >= 0; v -= 10) send(32'(v));
    end_frame();
    chk("mr_done_after", 64'(sif.done), 64'd1);
    chk("mr_count_after", 64'(sif.count), 64'd8);
    chk("mr_flags_after", 64'({sif.order_err, sif.short_frame, sif.overflow}), 64'd0);
    rd("mr_rd2", 3'd2, 32'd50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
